div_ctrl: RTL and testbench
===========================

# div_ctrl

Execute-stage sequencer that drives the multicycle divider (`div`) from the requester side for `DIV`/`DIVU` instructions. It launches a divide, holds the divider's operand/start handshake, and raises a pipeline stall request until the result returns. It then presents HI/LO write-back and handles flush (annul) and downstream-stall cases. It is instanced in `ex` next to `div`.

## Interface
- No parameters; widths come from `defines.v` (`RegBus` 32b, `DoubleRegBus` 64b, `AluOpBus` 8b).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, **asynchronous, active-low**.
- `aluop_i` in 8: EX-stage opcode; acts only on `EXE_DIV_OP` and `EXE_DIVU_OP`.
- `reg1_i` in 32: dividend.
- `reg2_i` in 32: divisor.
- `flush_i` in 1: pipeline flush (exception); cancels the divide in flight.
- `stall_i` in 1: EX held by a later stage; blocks retiring the result.
- `div_result_i` in 64: divider result, {remainder, quotient}.
- `div_ready_i` in 1: divider result ready.
- `div_opdata1_o` out 32: registered dividend to divider.
- `div_opdata2_o` out 32: registered divisor to divider.
- `div_start_o` out 1: registered start.
- `signed_div_o` out 1: registered; 1 for `DIV`, 0 for `DIVU`.
- `div_annul_o` out 1: combinational cancel to divider.
- `stallreq_o` out 1: combinational pipeline stall request.
- `whilo_o` out 1: HI/LO write enable.
- `hi_o` out 32: remainder.
- `lo_o` out 32: quotient.

## Operation
- State register encodings are `DivCtrlIdle`, `DivCtrlBusy`, `DivCtrlDone` and `DivCtrlAbort`.
- **Reset:** state=IDLE. All outputs are 0, including opdata, `start`, `signed` and `hi`/`lo`. The result buffer `res_q`=0 and the abort counter=0.
- **IDLE:** `start`=0.
  - If `is_div` (aluop is DIV or DIVU) and `!flush_i`: `stallreq_o`=1.
  - On that edge, latch `reg1_i`/`reg2_i` into opdata, set `signed` from aluop, set `start`<=1, go to BUSY.
  - Otherwise stay in IDLE with `stallreq_o`=0.
- **BUSY:** `start`=1 and opdata/`signed` are held stable. `stallreq_o`=!`flush_i`.
  - `flush_i`=1: `div_annul_o`=1 in the same cycle, `start`<=0, abort counter<=0, go to ABORT. `flush_i` has priority over `div_ready_i`.
  - Else if `div_ready_i`=1: `res_q`<=`div_result_i`, `start`<=0, go to DONE.
- **DONE:** `whilo_o`=1, `hi_o`=`res_q[63:32]`, `lo_o`=`res_q[31:0]`, `stallreq_o`=0. `start`=0, which releases the divider to its free state.
  - `flush_i`=1: `whilo_o` is forced to 0 and the state goes to IDLE.
  - Else if `stall_i`=0: go to IDLE (instruction retires from EX).
  - Else hold DONE with outputs stable.
- **ABORT:** `start`=0, `div_annul_o`=1, `stallreq_o`=0. Stays exactly 2 cycles, then IDLE. This covers the divider being in on, by-zero or end state when the flush occurs.
- Outside DONE: `whilo_o`=0 and `hi_o`=`lo_o`=0.
- A divide can only launch from IDLE. A DIV arriving in EX while the block is in DONE or ABORT waits until IDLE.
- Divide by zero is not special-cased; the divider returns 0/0.

## Timing
- The DIV enters EX in cycle T (IDLE). Cycle T+1 is BUSY with `start`=1.
- Non-zero divisor:
  - `div_ready_i` first seen in T+36.
  - DONE in T+37; with `stall_i`=0 the instruction retires at the end of T+37.
  - `stallreq_o`=1 over T..T+36.
- Zero divisor: ready seen in T+4, DONE in T+5.
- Flush at cycle F (BUSY): annul in F, ABORT in F+1 and F+2, IDLE in F+3. A next DIV in F+3 launches normally.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. There is no result write.

## Structure
- Add `EXE_DIV_OP`/`EXE_DIVU_OP` (existing) and the four `DivCtrl*` 2-bit state encodings to `defines.v`.
- Single flat module, no sub-module. `ex` instantiates `div_ctrl` and `div` side by side, and `ctrl` ORs `stallreq_o` into the stall vector.

## Test plan
- DIVU 100/7: in DONE, `hi`=2, `lo`=14, `whilo`=1 at T+37; `stallreq` high for exactly 37 cycles.
- DIV 0xFFFFFFF9 (−7) / 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; `signed_div_o`=1 throughout BUSY.
- DIV x/0: DONE at T+5 with `hi`=`lo`=0.
- `flush_i` at T+10: `div_annul_o`=1 that cycle, ABORT for 2 cycles, no `whilo`. A DIVU 9/4 issued immediately after returns `hi`=1, `lo`=2.
- `stall_i`=1 for 3 cycles during DONE: `whilo`/`hi`/`lo` held for 4 cycles, then IDLE. A back-to-back second DIV launches the cycle after.
- `rst`=0 at T+20: all outputs 0 asynchronously; after release, a new DIVU 50/5 gives `lo`=10, `hi`=0.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared opcodes, widths and state encodings for the EX-stage divide sequencer.
package div_ctrl_pkg;
  localparam int REG_W      = 32;
  localparam int DREG_W     = 64;
  localparam int ALUOP_W    = 8;
  localparam int ABORT_CYCLES = 2;

  localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b00011011;

  typedef enum logic [1:0] {
    DivCtrlIdle  = 2'b00,
    DivCtrlBusy  = 2'b01,
    DivCtrlDone  = 2'b10,
    DivCtrlAbort = 2'b11
  } div_ctrl_state_e;

  function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction
endpackage

// File: rtl/div_ctrl.sv
// Requester-side sequencer for the multicycle divider: launches DIV/DIVU,
// stalls the pipeline until the result returns, then drives HI/LO write-back.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [REG_W-1:0]   reg1_i,
  input  logic [REG_W-1:0]   reg2_i,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic [DREG_W-1:0]  div_result_i,
  input  logic               div_ready_i,
  output logic [REG_W-1:0]   div_opdata1_o,
  output logic [REG_W-1:0]   div_opdata2_o,
  output logic               div_start_o,
  output logic               signed_div_o,
  output logic               div_annul_o,
  output logic               stallreq_o,
  output logic               whilo_o,
  output logic [REG_W-1:0]   hi_o,
  output logic [REG_W-1:0]   lo_o
);

  div_ctrl_state_e   state;
  logic [DREG_W-1:0] res_q;
  logic [1:0]        abort_cnt;
  logic              is_div;

  assign is_div = is_div_op(aluop_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= DivCtrlIdle;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      div_start_o   <= 1'b0;
      signed_div_o  <= 1'b0;
      res_q         <= '0;
      abort_cnt     <= '0;
    end else begin
      case (state)
        DivCtrlIdle: begin
          if (is_div && !flush_i) begin
            div_opdata1_o <= reg1_i;
            div_opdata2_o <= reg2_i;
            signed_div_o  <= (aluop_i == EXE_DIV_OP);
            div_start_o   <= 1'b1;
            state         <= DivCtrlBusy;
          end
        end
        DivCtrlBusy: begin
          if (flush_i) begin
            div_start_o <= 1'b0;
            abort_cnt   <= '0;
            state       <= DivCtrlAbort;
          end else if (div_ready_i) begin
            res_q       <= div_result_i;
            div_start_o <= 1'b0;
            state       <= DivCtrlDone;
          end
        end
        DivCtrlDone: begin
          if (flush_i || !stall_i) state <= DivCtrlIdle;
        end
        DivCtrlAbort: begin
          // Annul is held long enough for the divider to leave any of its states
          if (abort_cnt == 2'(ABORT_CYCLES - 1)) state <= DivCtrlIdle;
          else abort_cnt <= abort_cnt + 2'd1;
        end
        default: state <= DivCtrlIdle;
      endcase
    end
  end

  always_comb begin
    stallreq_o  = 1'b0;
    div_annul_o = 1'b0;
    whilo_o     = 1'b0;
    hi_o        = '0;
    lo_o        = '0;
    case (state)
      DivCtrlIdle:  stallreq_o = is_div && !flush_i;
      DivCtrlBusy: begin
        stallreq_o  = !flush_i;
        div_annul_o = flush_i;
      end
      DivCtrlDone: begin
        whilo_o = !flush_i;
        hi_o    = res_q[DREG_W-1:REG_W];
        lo_o    = res_q[REG_W-1:0];
      end
      DivCtrlAbort: div_annul_o = 1'b1;
      default: ;
    endcase
    // The IDLE stall request depends on aluop_i, so mask it while reset is held
    if (!rst) stallreq_o = 1'b0;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: table vectors, hand corner sequences and randomized divides.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  aluop = '0;
  logic [31:0] reg1 = '0, reg2 = '0;
  logic        flush = 1'b0, stall = 1'b0;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic [31:0] div_opdata1_o, div_opdata2_o, hi_o, lo_o;
  logic        div_start_o, signed_div_o, div_annul_o, stallreq_o, whilo_o;

  int vecs = 0;
  int errs = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2),
    .flush_i(flush), .stall_i(stall), .div_result_i(div_result_i),
    .div_ready_i(div_ready_i), .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o), .div_start_o(div_start_o),
    .signed_div_o(signed_div_o), .div_annul_o(div_annul_o),
    .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: {remainder, quotient}, truncating division, x/0 = 0/0
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider environment: ready seen 35 start-cycles in (3 for a zero divisor)
  logic [5:0] dcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt <= '0; div_ready_i <= 1'b0; div_result_i <= '0;
    end else if (!div_start_o || div_annul_o) begin
      dcnt <= '0; div_ready_i <= 1'b0;
    end else begin
      dcnt <= dcnt + 6'd1;
      if (int'(dcnt) + 1 >= ((div_opdata2_o == 32'd0) ? 3 : 35)) begin
        div_ready_i  <= 1'b1;
        div_result_i <= ref_div(signed_div_o, div_opdata1_o, div_opdata2_o);
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin errs++; $display("FAIL %s: got %0h expected %0h", name, act, exp); end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin errs++; $display("FAIL %s: got %0h expected %0h", name, act, exp); end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin errs++; $display("FAIL %s: got %0d expected %0d", name, act, exp); end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, " start"}, div_start_o, 1'b0);
    chk1({tag, " signed"}, signed_div_o, 1'b0);
    chk32({tag, " opdata1"}, div_opdata1_o, 32'd0);
    chk32({tag, " opdata2"}, div_opdata2_o, 32'd0);
    chk1({tag, " annul"}, div_annul_o, 1'b0);
    chk1({tag, " stallreq"}, stallreq_o, 1'b0);
    chk1({tag, " whilo"}, whilo_o, 1'b0);
    chk32({tag, " hi"}, hi_o, 32'd0);
    chk32({tag, " lo"}, lo_o, 32'd0);
  endtask

  // hold: extra DONE cycles under stall_i; -1 = flush while in DONE.
  // flush_at > 0: flush in that BUSY cycle counted from launch.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int flush_at,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int lat, stall_cnt, done_t;
    logic sgn, busy_ok;
    sgn = (op == EXE_DIV_OP);
    lat = (b == 32'd0) ? 5 : 37;
    stall_cnt = 0; done_t = -1; busy_ok = 1'b1;
    @(negedge clk);
    aluop = op; reg1 = a; reg2 = b; flush = 1'b0; stall = 1'b0;
    #1;
    chk1({tag, " launch stallreq"}, stallreq_o, 1'b1);
    chk1({tag, " launch annul"}, div_annul_o, 1'b0);
    chk1({tag, " launch whilo"}, whilo_o, 1'b0);
    if (flush_at > 0) begin
      stall_cnt = 1;
      for (int t = 1; t < flush_at; t++) begin
        @(negedge clk); reg1 = $urandom; reg2 = $urandom; #1;
        if (stallreq_o) stall_cnt++;
      end
      @(negedge clk); flush = 1'b1; #1;
      chk1({tag, " flush annul"}, div_annul_o, 1'b1);
      chk1({tag, " flush stallreq"}, stallreq_o, 1'b0);
      chkn({tag, " stall cycles before flush"}, stall_cnt, flush_at);
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk); flush = 1'b0; aluop = '0; #1;
        chk1($sformatf("%s abort%0d annul", tag, k), div_annul_o, 1'b1);
        chk1($sformatf("%s abort%0d start", tag, k), div_start_o, 1'b0);
        chk1($sformatf("%s abort%0d whilo", tag, k), whilo_o, 1'b0);
        chk1($sformatf("%s abort%0d stallreq", tag, k), stallreq_o, 1'b0);
      end
      return;
    end
    if (stallreq_o) stall_cnt++;
    for (int t = 1; t <= lat + 5 && done_t < 0; t++) begin
      @(negedge clk); reg1 = $urandom; reg2 = $urandom; #1;
      if (stallreq_o) stall_cnt++;
      if (whilo_o) done_t = t;
      else if (div_start_o !== 1'b1 || signed_div_o !== sgn ||
               div_opdata1_o !== a || div_opdata2_o !== b) busy_ok = 1'b0;
    end
    chkn({tag, " done cycle"}, done_t, lat);
    chkn({tag, " stallreq cycles"}, stall_cnt, lat);
    chk1({tag, " busy operands/start/signed"}, busy_ok, 1'b1);
    chk1({tag, " done stallreq"}, stallreq_o, 1'b0);
    chk1({tag, " done start"}, div_start_o, 1'b0);
    chk32({tag, " hi"}, hi_o, exp_hi);
    chk32({tag, " lo"}, lo_o, exp_lo);
    if (hold < 0) begin
      stall = 1'b1;
      @(negedge clk); flush = 1'b1; aluop = '0; #1;
      chk1({tag, " whilo under flush"}, whilo_o, 1'b0);
      return;
    end
    stall = (hold > 0);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      if (h == hold) stall = 1'b0;
      #1;
      chk1($sformatf("%s hold%0d whilo", tag, h), whilo_o, 1'b1);
      chk32($sformatf("%s hold%0d hi", tag, h), hi_o, exp_hi);
      chk32($sformatf("%s hold%0d lo", tag, h), lo_o, exp_lo);
    end
    aluop = '0;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b;
    int          hold, flush_at;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{EXE_DIVU_OP, 32'd100,        32'd7,          0, 0, 32'd2,          32'd14};
    tbl[1] = '{EXE_DIV_OP,  32'hFFFF_FFF9,  32'd2,          0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFD};
    tbl[2] = '{EXE_DIV_OP,  32'd123,        32'd0,          0, 0, 32'd0,          32'd0};
    tbl[3] = '{EXE_DIVU_OP, 32'd77,         32'd3,          0, 10, 32'd0,         32'd0};
    tbl[4] = '{EXE_DIVU_OP, 32'd9,          32'd4,          0, 0, 32'd1,          32'd2};
    tbl[5] = '{EXE_DIVU_OP, 32'd1000,       32'd10,         3, 0, 32'd0,          32'd100};
    tbl[6] = '{EXE_DIV_OP,  32'd20,         32'hFFFF_FFFD,  0, 0, 32'd2,          32'hFFFF_FFFA};
    tbl[7] = '{EXE_DIVU_OP, 32'd7,          32'd0,         -1, 0, 32'd0,          32'd0};
    tbl[8] = '{EXE_DIVU_OP, 32'd17,         32'd5,          0, 0, 32'd2,          32'd3};

    // Reset state, with a DIV already on the opcode bus
    aluop = EXE_DIV_OP; reg1 = 32'd5; reg2 = 32'd1;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b1; aluop = '0;

    // IDLE with flush: no launch
    @(negedge clk); aluop = EXE_DIV_OP; flush = 1'b1; #1;
    chk1("idle flush stallreq", stallreq_o, 1'b0);
    @(negedge clk); aluop = '0; flush = 1'b0; #1;
    chk1("idle flush no start", div_start_o, 1'b0);

    // Table vectors, back to back
    foreach (tbl[i])
      run_div(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].flush_at,
              tbl[i].hi, tbl[i].lo, $sformatf("tbl%0d", i));

    // Reset asserted at T+20 of an in-flight DIVU
    @(negedge clk); aluop = EXE_DIVU_OP; reg1 = 32'd123; reg2 = 32'd7;
    repeat (20) @(negedge clk);
    rst = 1'b0; #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1; aluop = '0;
    run_div(EXE_DIVU_OP, 32'd50, 32'd5, 0, 0, 32'd0, 32'd10, "post-reset");

    // Randomized divides against the arithmetic model
    for (int n = 0; n < 16; n++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      logic [63:0] e;
      int hold, fa, lat;
      op = ($urandom_range(0, 1) == 1) ? EXE_DIV_OP : EXE_DIVU_OP;
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (op == EXE_DIV_OP && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat  = (b == 32'd0) ? 5 : 37;
      hold = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
      fa   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat - 1) : 0;
      e    = ref_div(op == EXE_DIV_OP, a, b);
      run_div(op, a, b, hold, fa, e[63:32], e[31:0], $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); aluop = '0; flush = 1'b0; stall = 1'b0;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
